// File: rtl/ddr2_v10_1_sequencer_avl_master.sv
// Avalon-MM master for the sequencer: drains a small command FIFO one transfer at a
// time, forces an idle bus cycle between transfers and aborts transfers that stall.
//
// state | meaning
// IDLE  | no transfer in flight, waiting for a queued command
// ISSUE | request asserted and held, waiting for waitrequest low or the watchdog
// GAP   | request lines low for one cycle so the slave can return to idle
module ddr2_v10_1_sequencer_avl_master #(
    parameter int AVL_DATA_WIDTH = 32,
    parameter int AVL_ADDR_WIDTH = 16,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      avl_clk,
    input  logic                      avl_reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AVL_ADDR_WIDTH-1:0] cmd_address,
    input  logic [AVL_DATA_WIDTH-1:0] cmd_writedata,
    output logic [AVL_ADDR_WIDTH-1:0] avl_address,
    output logic                      avl_write,
    output logic [AVL_DATA_WIDTH-1:0] avl_writedata,
    output logic                      avl_read,
    input  logic [AVL_DATA_WIDTH-1:0] avl_readdata,
    input  logic                      avl_waitrequest,
    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic [AVL_DATA_WIDTH-1:0] rsp_readdata,
    output logic                      rsp_timeout,
    output logic                      busy
);
    localparam int PW  = $clog2(CMD_FIFO_DEPTH);
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int EW  = 1 + AVL_ADDR_WIDTH + AVL_DATA_WIDTH;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t                    state_q;
    logic [PW:0]               wptr_q, rptr_q, wptr_d, rptr_d;
    logic [EW-1:0]             mem_q [CMD_FIFO_DEPTH];
    logic [EW-1:0]             head;
    logic                      empty, full, push, pop, busy_d;
    logic [WDW-1:0]            wd_q;
    logic [AVL_ADDR_WIDTH-1:0] avl_address_q;
    logic [AVL_DATA_WIDTH-1:0] avl_writedata_q, rsp_readdata_q;
    logic                      avl_write_q, avl_read_q;
    logic                      rsp_valid_q, rsp_write_q, rsp_timeout_q, busy_q;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
    assign push   = cmd_valid && !full;
    assign pop    = ((state_q == IDLE) || (state_q == GAP)) && !empty;
    assign wptr_d = wptr_q + {{PW{1'b0}}, push};
    assign rptr_d = rptr_q + {{PW{1'b0}}, pop};
    assign head   = mem_q[rptr_q[PW-1:0]];
    // busy tracks the state after this edge so it rises the cycle after an accept
    assign busy_d = (wptr_d != rptr_d) || (state_q == ISSUE) || pop;

    always_ff @(posedge avl_clk) begin
        if (push) begin
            mem_q[wptr_q[PW-1:0]] <= {cmd_write, cmd_address, cmd_writedata};
        end
    end

    always_ff @(posedge avl_clk or posedge avl_reset) begin
        if (avl_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge avl_clk or posedge avl_reset) begin
        if (avl_reset) begin
            state_q         <= IDLE;
            wd_q            <= '0;
            avl_address_q   <= '0;
            avl_writedata_q <= '0;
            avl_write_q     <= 1'b0;
            avl_read_q      <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_write_q     <= 1'b0;
            rsp_readdata_q  <= '0;
            rsp_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= busy_d;
            case (state_q)
                IDLE, GAP: begin
                    if (pop) begin
                        avl_write_q     <= head[EW-1];
                        avl_read_q      <= !head[EW-1];
                        avl_address_q   <= head[EW-2 -: AVL_ADDR_WIDTH];
                        avl_writedata_q <= head[AVL_DATA_WIDTH-1:0];
                        wd_q            <= '0;
                        state_q         <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    // completion wins over the watchdog on the same edge
                    if (!avl_waitrequest || (wd_q == WD_LAST)) begin
                        avl_write_q    <= 1'b0;
                        avl_read_q     <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        rsp_write_q    <= avl_write_q;
                        rsp_timeout_q  <= avl_waitrequest;
                        rsp_readdata_q <= (avl_read_q && !avl_waitrequest) ? avl_readdata : '0;
                        state_q        <= GAP;
                    end else if (wd_q != WD_MAX) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = !full;
    assign avl_address   = avl_address_q;
    assign avl_writedata = avl_writedata_q;
    assign avl_write     = avl_write_q;
    assign avl_read      = avl_read_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_readdata  = rsp_readdata_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;

endmodule
